// File: rtl/fetch_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-side bundle signals and decode-side delivery signals of
//               the fetch queue. The slave modport is the queue itself; the
//               master modport is the fetch/decode pair around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Fetch side
   logic                  flush;
   logic [ADDR_WIDTH-1:0] instruction_addr_0;
   logic [ADDR_WIDTH-1:0] instruction_addr_1;
   logic [DATA_WIDTH-1:0] instruction_0;
   logic [DATA_WIDTH-1:0] instruction_1;
   logic [1:0]            instruction_valid;
   logic                  predict_taken;
   logic [ADDR_WIDTH-1:0] predict_target;
   logic                  fetch_stall;

   // Decode side
   logic [ADDR_WIDTH-1:0] dec_addr_0;
   logic [ADDR_WIDTH-1:0] dec_addr_1;
   logic [DATA_WIDTH-1:0] dec_instr_0;
   logic [DATA_WIDTH-1:0] dec_instr_1;
   logic                  dec_pred_taken_0;
   logic                  dec_pred_taken_1;
   logic [ADDR_WIDTH-1:0] dec_pred_target_0;
   logic [ADDR_WIDTH-1:0] dec_pred_target_1;
   logic [1:0]            dec_valid;
   logic                  dec_ready;

   modport master (
      output flush,
      output instruction_addr_0,
      output instruction_addr_1,
      output instruction_0,
      output instruction_1,
      output instruction_valid,
      output predict_taken,
      output predict_target,
      input  fetch_stall,
      input  dec_addr_0,
      input  dec_addr_1,
      input  dec_instr_0,
      input  dec_instr_1,
      input  dec_pred_taken_0,
      input  dec_pred_taken_1,
      input  dec_pred_target_0,
      input  dec_pred_target_1,
      input  dec_valid,
      output dec_ready
   );

   modport slave (
      input  flush,
      input  instruction_addr_0,
      input  instruction_addr_1,
      input  instruction_0,
      input  instruction_1,
      input  instruction_valid,
      input  predict_taken,
      input  predict_target,
      output fetch_stall,
      output dec_addr_0,
      output dec_addr_1,
      output dec_instr_0,
      output dec_instr_1,
      output dec_pred_taken_0,
      output dec_pred_taken_1,
      output dec_pred_target_0,
      output dec_pred_target_1,
      output dec_valid,
      input  dec_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between fetch and decode. Accepts
//               a two-wide fetch bundle per cycle, delivers up to two
//               in-order entries per cycle, back-pressures fetch when fewer
//               than two slots remain, and empties in one cycle on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8     // power of two, at least 4
) (
   input  logic          clk,
   input  logic          rst,       // asynchronous, active low
   fetch_queue_if.slave  bus
);

   localparam int                 c_ptr_w       = $clog2(DEPTH);
   localparam int                 c_cnt_w       = c_ptr_w + 1;
   // Stall once fewer than two free entries remain, so a full bundle always fits.
   localparam logic [c_cnt_w-1:0] c_stall_level = c_cnt_w'(DEPTH - 2);
   localparam logic [c_ptr_w-1:0] c_ptr_one     = c_ptr_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_two     = c_cnt_w'(2);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] instr;
      logic                  pred_taken;
      logic [ADDR_WIDTH-1:0] pred_target;
   } entry_t;

   // Storage (not reset) and its next value
   entry_t               mem_q [DEPTH];
   entry_t               mem_d [DEPTH];

   // Pointers and occupancy
   logic [c_ptr_w-1:0]   head_q,  head_d;
   logic [c_ptr_w-1:0]   tail_q,  tail_d;
   logic [c_cnt_w-1:0]   count_q, count_d;

   // Derived from registered state only
   logic                 fetch_stall;
   logic [1:0]           dec_valid;
   entry_t               slot0;
   entry_t               slot1;

   // Enqueue / dequeue control
   logic                 enq_ok;
   logic                 deq_ok;
   logic [c_cnt_w-1:0]   enq_n;
   logic [c_cnt_w-1:0]   deq_n;
   entry_t               bundle_e0;
   entry_t               bundle_e1;

   // Back-pressure and delivery view, decoded from registered count/head
   always_comb begin
      fetch_stall  = (count_q > c_stall_level);
      dec_valid[0] = (count_q >= c_cnt_one);
      dec_valid[1] = (count_q >= c_cnt_two);
      slot0        = '0;
      slot1        = '0;
      if (dec_valid[0]) begin
         slot0 = mem_q[head_q];
      end
      if (dec_valid[1]) begin
         slot1 = mem_q[head_q + c_ptr_one];
      end
   end

   // Shape the incoming bundle; prediction rides on the last written entry
   always_comb begin
      bundle_e0.addr        = bus.instruction_addr_0;
      bundle_e0.instr       = bus.instruction_0;
      bundle_e0.pred_taken  = 1'b0;
      bundle_e0.pred_target = '0;
      bundle_e1.addr        = bus.instruction_addr_1;
      bundle_e1.instr       = bus.instruction_1;
      bundle_e1.pred_taken  = bus.predict_taken;
      bundle_e1.pred_target = bus.predict_target;
      // Slot 0 is the last written entry only when slot 1 is absent
      if (bus.instruction_valid == 2'b01) begin
         bundle_e0.pred_taken  = bus.predict_taken;
         bundle_e0.pred_target = bus.predict_target;
      end
   end

   // Next-state for storage, pointers and count; flush overrides everything
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      enq_n   = '0;
      deq_n   = '0;
      enq_ok  = !fetch_stall && !bus.flush;
      deq_ok  = bus.dec_ready && !bus.flush;

      if (enq_ok) begin
         case (bus.instruction_valid)
            2'b11: begin
               mem_d[tail_q]             = bundle_e0;
               mem_d[tail_q + c_ptr_one] = bundle_e1;
               enq_n                     = c_cnt_two;
            end
            2'b01: begin
               mem_d[tail_q] = bundle_e0;
               enq_n         = c_cnt_one;
            end
            2'b10: begin
               mem_d[tail_q] = bundle_e1;
               enq_n         = c_cnt_one;
            end
            default: begin
               enq_n = '0;
            end
         endcase
      end

      // dec_valid is thermometer coded, so its popcount is simple
      if (deq_ok) begin
         if (dec_valid[1]) begin
            deq_n = c_cnt_two;
         end else if (dec_valid[0]) begin
            deq_n = c_cnt_one;
         end
      end

      tail_d  = tail_q + enq_n[c_ptr_w-1:0];
      head_d  = head_q + deq_n[c_ptr_w-1:0];
      count_d = count_q + enq_n - deq_n;

      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Entry storage: plain registers, contents are don't-care until counted
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and occupancy registers with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign bus.fetch_stall       = fetch_stall;
   assign bus.dec_valid         = dec_valid;
   assign bus.dec_addr_0        = slot0.addr;
   assign bus.dec_addr_1        = slot1.addr;
   assign bus.dec_instr_0       = slot0.instr;
   assign bus.dec_instr_1       = slot1.instr;
   assign bus.dec_pred_taken_0  = slot0.pred_taken;
   assign bus.dec_pred_taken_1  = slot1.pred_taken;
   assign bus.dec_pred_target_0 = slot0.pred_target;
   assign bus.dec_pred_target_1 = slot1.pred_target;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH = 8).
//               Instruction words are the bitwise inverse of their address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fetch_queue_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fetch_queue #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a bundle on the fetch side
   task automatic set_bundle(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] v, input logic pt, input logic [31:0] tgt);
      bus.instruction_addr_0 = a0;
      bus.instruction_addr_1 = a1;
      bus.instruction_0      = ~a0;
      bus.instruction_1      = ~a1;
      bus.instruction_valid  = v;
      bus.predict_taken      = pt;
      bus.predict_target     = tgt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      bus.flush     = 1'b0;
      bus.dec_ready = 1'b0;
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      #2;
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl got valid=%b stall=%b exp valid=00 stall=0", bus.dec_valid, bus.fetch_stall);
      end
      checks++;
      if ({bus.dec_addr_0, bus.dec_addr_1, bus.dec_instr_0, bus.dec_instr_1} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %h exp all zero", bus.dec_addr_0, bus.dec_addr_1, bus.dec_instr_0, bus.dec_instr_1);
      end
      checks++;
      if ({bus.dec_pred_taken_0, bus.dec_pred_taken_1, bus.dec_pred_target_0, bus.dec_pred_target_1} !== 66'h0) begin
         errors++;
         $display("FAIL reset_pred got %b %b %h %h exp all zero", bus.dec_pred_taken_0, bus.dec_pred_taken_1, bus.dec_pred_target_0, bus.dec_pred_target_1);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got valid=%b stall=%b exp 00/0", bus.dec_valid, bus.fetch_stall);
      end
   endtask

   task automatic test_basic();
      set_bundle(32'h100, 32'h104, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b110) begin
         errors++;
         $display("FAIL basic_ctrl got valid=%b stall=%b exp 11/0", bus.dec_valid, bus.fetch_stall);
      end
      checks++;
      if ({bus.dec_addr_0, bus.dec_addr_1} !== {32'h100, 32'h104}) begin
         errors++;
         $display("FAIL basic_addr got %h/%h exp 100/104", bus.dec_addr_0, bus.dec_addr_1);
      end
      checks++;
      if ({bus.dec_instr_0, bus.dec_instr_1} !== {~32'h100, ~32'h104}) begin
         errors++;
         $display("FAIL basic_instr got %h/%h exp %h/%h", bus.dec_instr_0, bus.dec_instr_1, ~32'h100, ~32'h104);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      bus.dec_ready = 1'b1;
      step();
      checks++;
      if (bus.dec_valid !== 2'b00) begin
         errors++;
         $display("FAIL basic_drain got valid=%b exp 00", bus.dec_valid);
      end
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_full_drop();
      for (int k = 0; k < 4; k++) begin
         set_bundle(32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 2'b11, 1'b0, 32'h0);
         step();
         checks++;
         if (bus.fetch_stall !== (k == 3)) begin
            errors++;
            $display("FAIL fill_stall bundle %0d got %b exp %b", k, bus.fetch_stall, (k == 3));
         end
      end
      // Bundle offered while stalled must be dropped
      set_bundle(32'h200, 32'h204, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.fetch_stall, bus.dec_addr_0} !== {1'b1, 32'h1000}) begin
         errors++;
         $display("FAIL full_hold got stall=%b addr0=%h exp 1/1000", bus.fetch_stall, bus.dec_addr_0);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      bus.dec_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if ({bus.dec_valid, bus.fetch_stall, bus.dec_addr_0, bus.dec_addr_1} !==
             {2'b11, (j == 0), 32'h1000 + 32'(8*j), 32'h1004 + 32'(8*j)}) begin
            errors++;
            $display("FAIL drain_order step %0d got valid=%b stall=%b %h/%h exp 11/%b %h/%h", j,
                     bus.dec_valid, bus.fetch_stall, bus.dec_addr_0, bus.dec_addr_1,
                     (j == 0), 32'h1000 + 32'(8*j), 32'h1004 + 32'(8*j));
         end
         step();
      end
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b000) begin
         errors++;
         $display("FAIL drain_empty got valid=%b stall=%b exp 00/0 (dropped bundle stored?)", bus.dec_valid, bus.fetch_stall);
      end
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_predict();
      set_bundle(32'h300, 32'h304, 2'b11, 1'b1, 32'h400);
      step();
      checks++;
      if ({bus.dec_pred_taken_0, bus.dec_pred_target_0, bus.dec_pred_taken_1, bus.dec_pred_target_1} !==
          {1'b0, 32'h0, 1'b1, 32'h400}) begin
         errors++;
         $display("FAIL pred_pair got %b/%h %b/%h exp 0/0 1/400", bus.dec_pred_taken_0, bus.dec_pred_target_0,
                  bus.dec_pred_taken_1, bus.dec_pred_target_1);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      bus.dec_ready = 1'b1;
      step();
      bus.dec_ready = 1'b0;
      // Slot 1 only: it is the last written entry and lands at the head
      set_bundle(32'h4F0, 32'h500, 2'b10, 1'b1, 32'h600);
      step();
      checks++;
      if ({bus.dec_valid, bus.dec_addr_0, bus.dec_instr_0, bus.dec_pred_taken_0, bus.dec_pred_target_0} !==
          {2'b01, 32'h500, ~32'h500, 1'b1, 32'h600}) begin
         errors++;
         $display("FAIL pred_slot1_only got valid=%b %h %h %b %h exp 01 500 %h 1 600", bus.dec_valid,
                  bus.dec_addr_0, bus.dec_instr_0, bus.dec_pred_taken_0, bus.dec_pred_target_0, ~32'h500);
      end
      checks++;
      if ({bus.dec_addr_1, bus.dec_instr_1, bus.dec_pred_taken_1, bus.dec_pred_target_1} !== 97'h0) begin
         errors++;
         $display("FAIL pred_slot1_zero got %h %h %b %h exp all zero", bus.dec_addr_1, bus.dec_instr_1,
                  bus.dec_pred_taken_1, bus.dec_pred_target_1);
      end
      // Slot 0 only: prediction attaches to slot 0
      set_bundle(32'h700, 32'h7F0, 2'b01, 1'b1, 32'h800);
      step();
      checks++;
      if ({bus.dec_valid, bus.dec_addr_0, bus.dec_addr_1, bus.dec_pred_taken_1, bus.dec_pred_target_1} !==
          {2'b11, 32'h500, 32'h700, 1'b1, 32'h800}) begin
         errors++;
         $display("FAIL pred_slot0_only got valid=%b %h %h %b %h exp 11 500 700 1 800", bus.dec_valid,
                  bus.dec_addr_0, bus.dec_addr_1, bus.dec_pred_taken_1, bus.dec_pred_target_1);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      bus.dec_ready = 1'b1;
      step();
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_stream();
      bus.dec_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         set_bundle(32'h8000 + 32'(8*k), 32'h8004 + 32'(8*k), 2'b11, 1'b0, 32'h0);
         step();
         checks++;
         if ({bus.dec_valid, bus.fetch_stall, bus.dec_addr_0, bus.dec_addr_1, bus.dec_instr_1} !==
             {2'b11, 1'b0, 32'h8000 + 32'(8*k), 32'h8004 + 32'(8*k), ~(32'h8004 + 32'(8*k))}) begin
            errors++;
            $display("FAIL stream bundle %0d got valid=%b stall=%b %h/%h instr1=%h exp 11/0 %h/%h", k,
                     bus.dec_valid, bus.fetch_stall, bus.dec_addr_0, bus.dec_addr_1, bus.dec_instr_1,
                     32'h8000 + 32'(8*k), 32'h8004 + 32'(8*k));
         end
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      step();
      checks++;
      if (bus.dec_valid !== 2'b00) begin
         errors++;
         $display("FAIL stream_end got valid=%b exp 00", bus.dec_valid);
      end
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_flush();
      set_bundle(32'hA00, 32'hA04, 2'b11, 1'b0, 32'h0);
      step();
      set_bundle(32'hA08, 32'hA0C, 2'b11, 1'b0, 32'h0);
      step();
      set_bundle(32'hA10, 32'hA14, 2'b01, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.dec_valid, bus.fetch_stall, bus.dec_addr_0} !== {2'b11, 1'b0, 32'hA00}) begin
         errors++;
         $display("FAIL flush_setup got valid=%b stall=%b addr0=%h exp 11/0/a00", bus.dec_valid, bus.fetch_stall, bus.dec_addr_0);
      end
      bus.flush     = 1'b1;
      bus.dec_ready = 1'b1;
      set_bundle(32'hB00, 32'hB04, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b000) begin
         errors++;
         $display("FAIL flush_empty got valid=%b stall=%b exp 00/0", bus.dec_valid, bus.fetch_stall);
      end
      bus.flush     = 1'b0;
      bus.dec_ready = 1'b0;
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      step();
      checks++;
      if (bus.dec_valid !== 2'b00) begin
         errors++;
         $display("FAIL flush_discard got valid=%b exp 00", bus.dec_valid);
      end
      set_bundle(32'hC00, 32'hC04, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.dec_valid, bus.dec_addr_0, bus.dec_addr_1} !== {2'b11, 32'hC00, 32'hC04}) begin
         errors++;
         $display("FAIL flush_resume got valid=%b %h/%h exp 11 c00/c04", bus.dec_valid, bus.dec_addr_0, bus.dec_addr_1);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      bus.dec_ready = 1'b1;
      step();
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) begin
         set_bundle(32'hD00 + 32'(8*k), 32'hD04 + 32'(8*k), 2'b11, 1'b0, 32'h0);
         step();
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      checks++;
      if ({bus.dec_valid, bus.fetch_stall} !== 3'b111) begin
         errors++;
         $display("FAIL areset_full got valid=%b stall=%b exp 11/1", bus.dec_valid, bus.fetch_stall);
      end
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.dec_valid, bus.fetch_stall, bus.dec_addr_0} !== {3'b000, 32'h0}) begin
         errors++;
         $display("FAIL areset_immediate got valid=%b stall=%b addr0=%h exp 00/0/0", bus.dec_valid, bus.fetch_stall, bus.dec_addr_0);
      end
      @(negedge clk);
      rst = 1'b1;
      set_bundle(32'hE00, 32'hE04, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if ({bus.dec_valid, bus.fetch_stall, bus.dec_addr_0, bus.dec_addr_1} !== {2'b11, 1'b0, 32'hE00, 32'hE04}) begin
         errors++;
         $display("FAIL areset_after got valid=%b stall=%b %h/%h exp 11/0 e00/e04", bus.dec_valid, bus.fetch_stall,
                  bus.dec_addr_0, bus.dec_addr_1);
      end
      // Two more bundles bring occupancy to 6: still below the stall level
      set_bundle(32'hE08, 32'hE0C, 2'b11, 1'b0, 32'h0);
      step();
      set_bundle(32'hE10, 32'hE14, 2'b11, 1'b0, 32'h0);
      step();
      checks++;
      if (bus.fetch_stall !== 1'b0) begin
         errors++;
         $display("FAIL areset_count got stall=%b exp 0", bus.fetch_stall);
      end
      set_bundle(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_full_drop();
      test_predict();
      test_stream();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test sequence");
      $fatal(1);
   end

endmodule
`default_nettype wire
